// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-word reads to a
// 1-cycle-latency instruction memory and hands instructions to decode over
// a valid/ready handshake. A one-entry skid buffer catches the response that
// is already in flight when decode stalls. Redirects flush all wrong-path state.
// A misaligned redirect target raises a sticky fault that halts fetch until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  logic [31:0] r_pc_f;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_fault;

  logic        w_req;
  logic        w_advance;
  logic        w_misaligned;

  // Only request when the response is guaranteed a home: the skid must be
  // empty, and a stalled output with a response already in flight means that
  // response will take the skid, so nothing more may be issued.
  assign w_req = !rst && !r_fault && !redirect && !r_skid_valid &&
                 !(r_out_valid && !id_ready && r_inflight);

  // Output register may take new data when empty or being consumed.
  assign w_advance    = !r_out_valid || id_ready;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  assign imem_req    = w_req;
  assign imem_addr   = r_pc_f;
  assign id_valid    = r_out_valid;
  assign id_instr    = r_out_valid ? r_out_instr : NOP_INSTR;
  assign id_pc       = r_out_pc;
  assign id_pc_plus4 = r_out_pc + 32'd4;
  assign fetch_fault = r_fault;

  // PC, in-flight tracking and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f        <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_fault       <= 1'b0;
    end else if (redirect) begin
      // Any response arriving this cycle belongs to the wrong path.
      r_pc_f     <= redirect_pc;
      r_inflight <= 1'b0;
      if (w_misaligned) begin
        r_fault <= 1'b1;
      end
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc_f        <= r_pc_f + 32'd4;
        r_inflight_pc <= r_pc_f;
      end
    end
  end

  // Output register and skid buffer: skid drains first to keep program order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= 32'd0;
    end else if (redirect) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_advance) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_pc     <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (r_inflight) begin
        r_out_valid <= 1'b1;
        r_out_instr <= imem_rdata;
        r_out_pc    <= r_inflight_pc;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_inflight) begin
      // Stalled with a response landing: park it in the skid.
      r_skid_valid <= 1'b1;
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. The memory returns word (addr>>2) one cycle after a
// request. The reference model is a single "next expected PC" of the program
// stream: it restarts at RESET_PC on reset, jumps on redirect and steps by 4
// on every accepted instruction; any valid output must equal that PC.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;

  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata = 32'd0, imem_rdata2 = 32'd0;
  logic        id_valid, id_valid2;
  logic [31:0] id_instr, id_instr2, id_pc, id_pc2, id_pc_plus4, id_pc_plus42;
  logic        fetch_fault, fetch_fault2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid2), .id_instr(id_instr2),
    .id_pc(id_pc2), .id_pc_plus4(id_pc_plus42), .fetch_fault(fetch_fault2)
  );

  // Instruction memories: word i at address 4i, garbage when not requested.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  >> 2) : $urandom;
    imem_rdata2 <= imem_req2 ? (imem_addr2 >> 2) : $urandom;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Sampled view of the current cycle.
  logic        s_req, s_valid, s_fault, s_req2, s_valid2;
  logic [31:0] s_addr, s_instr, s_pc, s_p4, s_addr2, s_instr2, s_pc2, s_p42;
  // Inputs applied in the previous cycle, for the model update.
  logic        p_rst, p_rdy, p_redir, have_prev = 1'b0;
  logic [31:0] p_rpc;
  // Reference model.
  logic [31:0] exp_pc = 32'd0;
  logic        faulted = 1'b0;

  task automatic cyc(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    if (have_prev) begin
      if (p_rst) begin
        exp_pc  = 32'd0;
        faulted = 1'b0;
      end else if (p_redir) begin
        exp_pc = p_rpc;
        if (p_rpc[1:0] != 2'b00) faulted = 1'b1;
      end else if (s_valid && p_rdy) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(negedge clk);
    rst = r; id_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid; s_instr = id_instr;
    s_pc = id_pc; s_p4 = id_pc_plus4; s_fault = fetch_fault;
    s_req2 = imem_req2; s_addr2 = imem_addr2; s_valid2 = id_valid2; s_instr2 = id_instr2;
    s_pc2 = id_pc2; s_p42 = id_pc_plus42;
    p_rst = r; p_rdy = rdy; p_redir = rd; p_rpc = rpc; have_prev = 1'b1;
    if (s_valid && rdy && !r)
      $display("[TB] t=%0t accept pc=%h instr=%h", $time, s_pc, s_instr);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++;
    if (s_req !== 1'b0 || s_valid !== 1'b0 || s_instr !== NOP || s_pc !== 32'd0 || s_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state req=%b valid=%b instr=%h pc=%h fault=%b required 0/0/%h/0/0",
               s_req, s_valid, s_instr, s_pc, s_fault, NOP);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL reset_fetch k=%0d req=%b addr=%h required 1/%h", k, s_req, s_addr, 32'(4 * k));
      end
      n_tests++;
      if (s_valid !== (k >= 2)) begin
        n_fail++;
        $display("FAIL reset_latency k=%0d valid=%b required %b", k, s_valid, (k >= 2));
      end
      if (s_valid) begin
        n_tests++;
        if (s_pc !== exp_pc || s_instr !== (exp_pc >> 2) || s_p4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL reset_stream pc=%h instr=%h p4=%h required pc=%h", s_pc, s_instr, s_p4, exp_pc);
        end
      end
    end
  endtask

  task automatic test_stall();
    int hs;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      n_tests++;
      if (s_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req k=%0d req=%b required 0", k, s_req);
      end
      n_tests++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== (exp_pc >> 2) || s_p4 !== exp_pc + 32'd4) begin
        n_fail++;
        $display("FAIL stall_hold k=%0d valid=%b pc=%h instr=%h required pc=%h", k, s_valid, s_pc, s_instr, exp_pc);
      end
    end
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      if (s_valid) begin
        hs++;
        n_tests++;
        if (s_pc !== exp_pc || s_instr !== (exp_pc >> 2) || s_p4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL stall_resume pc=%h instr=%h p4=%h required pc=%h", s_pc, s_instr, s_p4, exp_pc);
        end
      end
    end
    n_tests++;
    if (hs != 7) begin
      n_fail++;
      $display("FAIL stall_resume_count accepted=%0d required 7", hs);
    end
  endtask

  task automatic test_redirect();
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    n_tests++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_req_R req=%b required 0", s_req);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      if (k == 1) begin
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
          n_fail++;
          $display("FAIL redirect_fetch req=%b addr=%h required 1/00000100", s_req, s_addr);
        end
      end
      n_tests++;
      if (s_valid !== (k >= 3)) begin
        n_fail++;
        $display("FAIL redirect_bubble R+%0d valid=%b required %b", k, s_valid, (k >= 3));
      end
      if (s_valid) begin
        n_tests++;
        if (s_pc !== 32'h100 + 32'(4 * (k - 3)) || s_instr !== (s_pc >> 2) || s_p4 !== s_pc + 32'd4) begin
          n_fail++;
          $display("FAIL redirect_stream R+%0d pc=%h instr=%h required pc=%h", k, s_pc, s_instr, 32'h100 + 32'(4 * (k - 3)));
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    n_tests++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_stall_R req=%b valid=%b required 0/1", s_req, s_valid);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      n_tests++;
      if (s_valid !== (k >= 3)) begin
        n_fail++;
        $display("FAIL redir_stall_bubble R+%0d valid=%b required %b", k, s_valid, (k >= 3));
      end
      if (k >= 3) begin
        n_tests++;
        if (s_pc !== 32'h200 + 32'(4 * (k - 3)) || s_instr !== (s_pc >> 2)) begin
          n_fail++;
          $display("FAIL redir_stall_pc R+%0d pc=%h instr=%h required pc=%h", k, s_pc, s_instr, 32'h200 + 32'(4 * (k - 3)));
        end
      end
    end
  endtask

  task automatic test_random();
    int hs;
    logic rdy, rd;
    logic [31:0] rpc;
    hs = 0;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 31) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      cyc(1'b0, rdy, rd, rpc);
      if (s_valid) begin
        if (rdy) hs++;
        n_tests++;
        if (s_pc !== exp_pc || s_instr !== (exp_pc >> 2) || s_p4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL random_stream k=%0d pc=%h instr=%h p4=%h required pc=%h", k, s_pc, s_instr, s_p4, exp_pc);
        end
      end else begin
        n_tests++;
        if (s_instr !== NOP) begin
          n_fail++;
          $display("FAIL random_nop k=%0d instr=%h required %h", k, s_instr, NOP);
        end
      end
      if (s_req) begin
        n_tests++;
        if (s_addr[1:0] !== 2'b00) begin
          n_fail++;
          $display("FAIL random_align addr=%h required low bits 00", s_addr);
        end
      end
    end
    n_tests++;
    if (hs < 100) begin
      n_fail++;
      $display("FAIL random_progress accepted=%0d required >=100", hs);
    end
  endtask

  task automatic test_fault();
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
      n_tests++;
      if (s_fault !== faulted || s_req !== 1'b0 || s_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_hold k=%0d fault=%b req=%b valid=%b required %b/0/0", k, s_fault, s_req, s_valid, faulted);
      end
    end
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      n_tests++;
      if (s_fault !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL fault_restart k=%0d fault=%b req=%b addr=%h required 0/1/%h", k, s_fault, s_req, s_addr, 32'(4 * k));
      end
      if (s_valid) begin
        n_tests++;
        if (s_pc !== exp_pc || s_instr !== (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL fault_restart_pc pc=%h instr=%h required pc=%h", s_pc, s_instr, exp_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wpc;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    wpc = 32'hFFFF_FFF8;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      if (k == 0) begin
        n_tests++;
        if (s_req2 !== 1'b1 || s_addr2 !== 32'hFFFF_FFF8) begin
          n_fail++;
          $display("FAIL wrap_fetch req=%b addr=%h required 1/fffffff8", s_req2, s_addr2);
        end
      end
      if (k >= 2) begin
        n_tests++;
        if (s_valid2 !== 1'b1 || s_pc2 !== wpc || s_instr2 !== (wpc >> 2) || s_p42 !== wpc + 32'd4) begin
          n_fail++;
          $display("FAIL wrap_stream k=%0d valid=%b pc=%h instr=%h p4=%h required pc=%h", k, s_valid2, s_pc2, s_instr2, s_p42, wpc);
        end
        if (wpc == 32'hFFFF_FFFC) begin
          n_tests++;
          if (s_p42 !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_plus4 p4=%h required 00000000", s_p42);
          end
        end
        wpc = wpc + 32'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_random();
    test_fault();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency. Presents fetched instructions to decode through a valid/ready handshake, with a one-entry skid buffer to absorb stalls. Accepts branch/jump redirects from execute and flushes all wrong-path state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction driven on id_instr when id_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req  output  1  read request this cycle; memory always accepts.
imem_addr  output  32  word address of request (bits [1:0] always 0).
imem_rdata  input  32  read data, valid exactly 1 cycle after the cycle imem_req=1.
redirect  input  1  taken branch/jump from execute, single-cycle pulse.
redirect_pc  input  32  new fetch target, sampled when redirect=1.
id_ready  input  1  decode can accept an instruction this cycle.
id_valid  output  1  id_instr/id_pc hold a valid instruction.
id_instr  output  32  instruction word to decoder.
id_pc  output  32  address of id_instr.
id_pc_plus4  output  32  id_pc+4, modulo 2^32.
fetch_fault  output  1  sticky: a misaligned redirect target was received.

Behaviour:
- Clock/reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset (rst=1 at an edge): pc_f<=RESET_PC; out_valid, skid_valid, inflight, fetch_fault <= 0; id_instr=NOP_INSTR; id_pc=0; imem_req=0 during rst cycles. rst overrides redirect and all other inputs.
- State: pc_f (next fetch address), inflight+inflight_pc (request issued last cycle), output register (out_valid, instr, pc), skid register (skid_valid, instr, pc).
- Request rule: imem_req = !rst && !fetch_fault && !redirect && !skid_valid && !(out_valid && !id_ready && inflight). imem_addr=pc_f. On issue: pc_f<=pc_f+4 (wraps 32'hFFFF_FFFC -> 0), inflight<=1, inflight_pc<=pc_f. Otherwise inflight<=0.
- Latency: request in cycle N -> imem_rdata in N+1 -> id_valid in N+2 (registered output). Steady state with id_ready=1: one instruction per cycle, consecutive id_pc values differ by 4.
- Output update each edge: if !out_valid or (id_valid && id_ready): load from skid if skid_valid (skid_valid<=0), else from response if inflight, else out_valid<=0. If out_valid && !id_ready: hold output; a returning response goes to skid.
- Invariant: skid_valid implies !inflight; no instruction is ever dropped or duplicated except by redirect.
- Stall: while id_valid=1 and id_ready=0, id_instr/id_pc/id_pc_plus4 stable.
- id_valid=0 -> id_instr=NOP_INSTR.
- Redirect at cycle R: out, skid, inflight cleared at edge end of R (response arriving in R discarded); pc_f<=redirect_pc; imem_req=0 in R. R+1: imem_req=1, imem_addr=redirect_pc. First redirected instruction id_valid at R+3. id_valid=0 in R+1 and R+2. Redirect overrides id_ready and any simultaneous handshake (instruction accepted in R is still consumed by decode; stage does not care).
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_fault<=1 at end of R; all valid state flushed; imem_req=0 and id_valid=0 until rst.

Test Plan:
- Reset release, memory holds word i at addr 4i, id_ready=1 -> imem_addr 0,4,8... from first post-reset cycle; id_valid 2 cycles later; id_pc 0,4,8 with matching instr, one per cycle.
- Hold id_ready=0 for 5 cycles mid-stream -> output frozen, skid fills once, imem_req drops; on release instructions resume in order with no gap-loss or duplicate.
- redirect=1, redirect_pc=32'h0000_0100 during streaming -> id_valid low for 2 cycles, next id_pc=0x100, then 0x104; pre-redirect in-flight words never appear.
- redirect coinciding with id_ready=0 and full skid -> all flushed; first id_pc after is redirect_pc.
- redirect_pc=32'h0000_0102 -> fetch_fault=1 next cycle, imem_req=0, id_valid=0 persistent; rst clears, fetch restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 for FFFF_FFFC = 0.
